// File: rtl/pe_mac_seq.sv
// Streaming Q-format dot-product PE: N_LANE MACs per beat, K beats per job,
// then bias/PReLU/saturate onto a valid/ready result port.

module pe_mac_lane #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   w,
  output logic [2*WIDTH-1:0] p
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  p <= '0;
    else if (en) p <= $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{w[WIDTH-1]}}, w});
endmodule

module pe_mac_seq #(
  parameter int WIDTH  = 32,
  parameter int FBITS  = 24,
  parameter int N_LANE = 8,
  parameter int KB     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KB-1:0]           k_beats,
  input  logic [WIDTH-1:0]        bias,
  input  logic                    mode,
  input  logic [WIDTH-1:0]        alpha,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_LANE*WIDTH-1:0] all_a,
  input  logic [N_LANE*WIDTH-1:0] all_w,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        y,
  output logic                    sat,
  output logic                    busy
);
  localparam int ACC_W  = 2*WIDTH + $clog2(N_LANE) + KB;
  localparam int PW     = ACC_W + WIDTH;
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  typedef struct packed {
    logic             mode;
    logic [WIDTH-1:0] alpha;
  } cfg_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             sat;
  } res_t;

  state_t                           state, state_nx;
  cfg_t                             cfg;
  res_t                             res, res_c;
  logic [KB-1:0]                    rem;
  logic [1:0]                       drain_cnt;
  logic [STAGES:0]                  vld_pipe;
  logic [N_LANE-1:0][2*WIDTH-1:0]   prod;
  logic signed [ACC_W-1:0]          acc, lane_sum, bias_ext, v_lin;
  logic signed [PW-1:0]             pm, v_fin;
  logic [PW-WIDTH:0]                hi;
  logic                             fire;

  assign in_ready  = (state == RUN);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign fire      = in_valid & in_ready;
  assign y         = res.y;
  assign sat       = res.sat;
  assign bias_ext  = $signed({{(ACC_W-WIDTH){bias[WIDTH-1]}}, bias});

  pe_mac_lane #(.WIDTH(WIDTH)) u_lane [N_LANE-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (fire),
    .a    (all_a),
    .w    (all_w),
    .p    (prod)
  );

  always_comb begin
    lane_sum = '0;
    for (int g = 0; g < N_LANE; g++)
      lane_sum = lane_sum + $signed({{(ACC_W-2*WIDTH){prod[g][2*WIDTH-1]}}, prod[g]});
  end

  // Finalize: descale, optional PReLU at full precision, then clamp to WIDTH.
  always_comb begin
    v_lin = acc >>> FBITS;
    pm    = $signed({{WIDTH{v_lin[ACC_W-1]}}, v_lin}) *
            $signed({{ACC_W{cfg.alpha[WIDTH-1]}}, cfg.alpha});
    v_fin = $signed({{WIDTH{v_lin[ACC_W-1]}}, v_lin});
    if (cfg.mode && v_lin[ACC_W-1]) v_fin = pm >>> FBITS;
    hi        = v_fin[PW-1:WIDTH-1];
    res_c.sat = ~(&hi | ~|hi);
    res_c.y   = v_fin[WIDTH-1:0];
    if (res_c.sat)
      res_c.y = v_fin[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (k_beats == '0) ? DRAIN : RUN;
      RUN:   if (fire && rem == KB'(1)) state_nx = DRAIN;
      // Wait for the product and accumulate stages to empty before finalizing.
      DRAIN: if (drain_cnt == 2'd2 && !(|vld_pipe)) state_nx = OUT;
      OUT:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= '0;
      rem       <= '0;
      cfg       <= '0;
      res       <= '0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], fire};
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == IDLE && start) begin
        rem       <= k_beats;
        cfg.mode  <= mode;
        cfg.alpha <= alpha;
        acc       <= bias_ext <<< FBITS;
      end else begin
        if (fire)        rem <= rem - KB'(1);
        if (vld_pipe[0]) acc <= acc + lane_sum;
      end
      if (state == DRAIN && state_nx == OUT) res <= res_c;
    end
endmodule

// File: doc/pe_mac_seq.md
Name: pe_mac_seq

Overview:
- Sequential, streaming successor of the combinational Q-format dot-product PE used in the SEGAN conv layers.
- Accepts N_LANE activation/weight pairs per beat over a valid/ready handshake and accumulates K beats into a wide accumulator.
- Adds bias, applies an optional PReLU, saturates to WIDTH bits and presents the result on a valid/ready output.
- Used wherever a kernel is longer than the number of lanes: one instance is time-multiplexed over the kernel instead of instantiating one multiplier per tap.

Parameters:
- WIDTH, 32, signed fixed-point word width.
- FBITS, 24, fractional bits (Q8.24 at default).
- N_LANE, 8, multipliers per beat.
- KB, 8, width of the beat-count input; max K = 2^KB-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new dot product; sampled only in IDLE.
- k_beats  in  KB  number of input beats for this job; sampled with start.
- bias  in  WIDTH  signed bias; sampled with start.
- mode  in  1  0 = linear, 1 = PReLU; sampled with start.
- alpha  in  WIDTH  signed PReLU slope (Q format); sampled with start.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- all_a  in  N_LANE*WIDTH  packed activations; lane g at [(g+1)*WIDTH-1 : g*WIDTH].
- all_w  in  N_LANE*WIDTH  packed weights, same packing as all_a.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- y  out  WIDTH  saturated result.
- sat  out  1  y was clamped; qualified by out_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready, out_valid, sat, busy, y = 0; accumulator, beat counter and pipeline valids cleared.
- Reset mid-operation aborts the job with no output; the first start after reset release is processed normally.
- FSM IDLE -> RUN -> DRAIN -> OUT -> IDLE:
  - IDLE: start=1 latches k_beats, bias, mode, alpha; loads acc = sign-extended bias << FBITS (see arithmetic below); goes to RUN. If k_beats=0 it goes directly to DRAIN.
  - RUN: in_ready=1. Each accepted beat decrements the remaining count. The cycle that accepts the last beat deasserts in_ready from the next cycle and goes to DRAIN. in_valid gaps are allowed and stall with no effect.
  - DRAIN: 2 cycles (product register, then accumulate). Then the output register is loaded and the FSM goes to OUT.
  - OUT: out_valid=1, y and sat held stable until out_ready=1. Transfer -> IDLE with out_valid=0 next cycle.
- start outside IDLE is ignored, including in the cycle of the OUT transfer. Next-job start is accepted one cycle after returning to IDLE.
- Latency: last beat accepted at edge T -> out_valid high after edge T+3. For k_beats=0: start at edge S -> out_valid after edge S+3.
- Pipeline per beat:
  - Stage 1 registers N_LANE full 2*WIDTH signed products.
  - Stage 2 adds the lane sum to acc.
  - Accumulator width is 2*WIDTH + clog2(N_LANE) + KB; it never wraps.
- Arithmetic:
  - Products are kept unshifted. The bias is aligned by << FBITS.
  - Final value v = acc >>> FBITS (arithmetic, truncation toward -inf).
  - PReLU (mode=1, v<0): v = (v*alpha) >>> FBITS at full precision. v>=0 or mode=0 leaves v unchanged.
  - Saturation: clamp v to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat=1 if clamped.
- in_valid while not in RUN is ignored; no beat is consumed.

Test Plan:
- Defaults, mode=0, k_beats=2, bias=0x0040_0000 (0.25), all a=0x0100_0000 (1.0), all w=0x0080_0000 (0.5), back-to-back beats -> y=0x0840_0000 (8.25), sat=0, out_valid 3 cycles after last beat.
- mode=1, alpha=0x0040_0000 (0.25), k_beats=1, bias=0, a=0xFF00_0000 (-1.0), w=1.0 -> pre-activation -8.0, y=0xFE00_0000 (-2.0); repeat with mode=0 -> y=0xF800_0000.
- k_beats=1, a=w=0x6400_0000 (100.0) -> y=0x7FFF_FFFF, sat=1; a=-100.0, w=100.0 -> y=0x8000_0000, sat=1.
- k_beats=3 with in_valid low 4 cycles between beats, out_ready low 5 cycles, start pulsed during OUT -> same result as gap-free, y stable while stalled, start ignored, busy=1 until transfer.
- k_beats=0, bias=0xFF80_0000 (-0.5), mode=1, alpha=0.25 -> y=0xFFE0_0000 (-0.125) 3 cycles after start, in_ready never asserted.
- rst_n pulsed low mid-RUN after 1 of 4 beats -> all outputs 0 immediately, state IDLE; new job k_beats=1 with a=w=1.0, bias=0 -> y=0x0800_0000 (8.0).
